// File: rtl/fpnew_pkg.sv
// Shared types and helpers for the FPnew non-computational slice.
// Provides FP format descriptors, rounding-mode / operation encodings, status flags,
// classification masks and the packed per-stage payload of the non-comp pipeline.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // Widest supported format; stage payloads carry results at this width.
  localparam int unsigned FLEN = 64;
  localparam int unsigned MAX_NONCOMP_PIPE_REGS = 4;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef enum logic [9:0] {
    NEGINF     = 10'b00_0000_0001,
    NEGNORM    = 10'b00_0000_0010,
    NEGSUBNORM = 10'b00_0000_0100,
    NEGZERO    = 10'b00_0000_1000,
    POSZERO    = 10'b00_0001_0000,
    POSSUBNORM = 10'b00_0010_0000,
    POSNORM    = 10'b00_0100_0000,
    POSINF     = 10'b00_1000_0000,
    SNAN       = 10'b01_0000_0000,
    QNAN       = 10'b10_0000_0000
  } classmask_e;

  typedef struct packed {
    logic [FLEN-1:0] result;
    status_t         status;
    logic            ext;
    classmask_e      class_mask;
    logic            is_class;
  } noncomp_result_t;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:       return 11;
      FP16, FP8:  return 5;
      default:    return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

endpackage

// File: rtl/fpnew_noncomp_stage.sv
// One elastic register stage with valid/ready handshake and flush.
// Ports: clk_i/rst_i (sync active-high), flush_i kills the held entry and any load this cycle;
// in_valid_i/in_ready_o/in_data_i upstream side, out_valid_o/out_ready_i/out_data_o downstream.
// The payload register only loads on an accepted transfer and is never reset.
module fpnew_noncomp_stage import fpnew_pkg::*; #(
  parameter type PayloadT = logic
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    flush_i,
  input  logic    in_valid_i,
  output logic    in_ready_o,
  input  PayloadT in_data_i,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output PayloadT out_data_o
);

  logic    valid_d, valid_q;
  PayloadT data_d, data_q;

  // Accept when empty or when the current entry leaves this cycle.
  assign in_ready_o = ~valid_q | out_ready_i;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (in_ready_o) begin
      valid_d = in_valid_i;
    end
  end

  always_comb begin
    data_d = data_q;
    if (in_valid_i && in_ready_o) begin
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/fpnew_noncomp_pipe.sv
// FPnew non-computational unit for a single FP format: SGNJ, MINMAX, CMP, CLASSIFY.
// Results are computed combinationally at the input and travel through NumPipeRegs elastic
// stages (0 = combinational pass-through) together with the tag/aux sideband.
// Ports: operands_i/is_boxed_i/rnd_mode_i/op_i/op_mod_i/tag_i/aux_i request payload,
// in_valid_i/in_ready_o request handshake, flush_i drops all in-flight work,
// result_o/status_o/extension_bit_o/class_mask_o/is_class_o/tag_o/aux_o response payload,
// out_valid_o/out_ready_i response handshake, busy_o while any stage holds data.
module fpnew_noncomp_pipe import fpnew_pkg::*; #(
  parameter fp_format_e  FpFormat    = fp_format_e'(0),
  parameter int unsigned NumPipeRegs = 1,
  parameter type         TagType     = logic,
  parameter type         AuxType     = logic,
  localparam int unsigned Width      = fp_width(FpFormat)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0][Width-1:0] operands_i,
  input  logic [1:0]            is_boxed_i,
  input  roundmode_e            rnd_mode_i,
  input  operation_e            op_i,
  input  logic                  op_mod_i,
  input  TagType                tag_i,
  input  AuxType                aux_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  output logic [Width-1:0]      result_o,
  output status_t               status_o,
  output logic                  extension_bit_o,
  output classmask_e            class_mask_o,
  output logic                  is_class_o,
  output TagType                tag_o,
  output AuxType                aux_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  localparam int unsigned ExpBits = exp_bits(FpFormat);
  localparam int unsigned ManBits = man_bits(FpFormat);
  localparam logic [Width-1:0] QNan = {1'b0, {ExpBits{1'b1}}, 1'b1, {(ManBits-1){1'b0}}};

  if (NumPipeRegs > MAX_NONCOMP_PIPE_REGS) begin : g_bad_cfg
    $error("NumPipeRegs out of range");
  end

  typedef struct packed {
    noncomp_result_t res;
    TagType          tag;
    AuxType          aux;
  } payload_t;

  // ---------------------------------------------------------------------------
  // Operand preparation and classification
  // ---------------------------------------------------------------------------
  logic [1:0][Width-1:0] opnd;
  logic [1:0]            sign, is_zero, is_inf, is_nan, is_snan;

  for (genvar i = 0; i < 2; i++) begin : g_operand
    logic [ExpBits-1:0] exp_v;
    logic [ManBits-1:0] man_v;
    // A non-boxed operand is replaced by the canonical qNaN before anything else.
    assign opnd[i]    = is_boxed_i[i] ? operands_i[i] : QNan;
    assign sign[i]    = opnd[i][Width-1];
    assign exp_v      = opnd[i][Width-2 -: ExpBits];
    assign man_v      = opnd[i][ManBits-1:0];
    assign is_zero[i] = (exp_v == '0) && (man_v == '0);
    assign is_inf[i]  = (exp_v == '1) && (man_v == '0);
    assign is_nan[i]  = (exp_v == '1) && (man_v != '0);
    assign is_snan[i] = is_nan[i] & ~man_v[ManBits-1];
  end

  logic is_subnormal_a;
  assign is_subnormal_a = (opnd[0][Width-2 -: ExpBits] == '0) & ~is_zero[0];

  logic any_nan, any_snan, both_zero;
  assign any_nan   = |is_nan;
  assign any_snan  = |is_snan;
  assign both_zero = &is_zero;

  // Sign-magnitude ordering in which -0 sorts below +0; used directly by MINMAX.
  logic a_below_b;
  always_comb begin
    if (sign[0] != sign[1]) begin
      a_below_b = sign[0];
    end else if (sign[0]) begin
      a_below_b = opnd[0][Width-2:0] > opnd[1][Width-2:0];
    end else begin
      a_below_b = opnd[0][Width-2:0] < opnd[1][Width-2:0];
    end
  end

  // IEEE comparisons treat the zeros as equal.
  logic cmp_eq, cmp_lt;
  assign cmp_eq = (opnd[0] == opnd[1]) | both_zero;
  assign cmp_lt = a_below_b & ~both_zero;

  classmask_e class_a;
  always_comb begin
    if (is_nan[0]) begin
      class_a = is_snan[0] ? SNAN : QNAN;
    end else if (is_inf[0]) begin
      class_a = sign[0] ? NEGINF : POSINF;
    end else if (is_zero[0]) begin
      class_a = sign[0] ? NEGZERO : POSZERO;
    end else if (is_subnormal_a) begin
      class_a = sign[0] ? NEGSUBNORM : POSSUBNORM;
    end else begin
      class_a = sign[0] ? NEGNORM : POSNORM;
    end
  end

  // ---------------------------------------------------------------------------
  // Operation select
  // ---------------------------------------------------------------------------
  logic [Width-1:0] res_w;
  logic             cmp_raw;
  noncomp_result_t  comp_res;

  always_comb begin
    res_w               = '0;
    cmp_raw             = 1'b0;
    comp_res            = '0;
    comp_res.class_mask = class_a;
    case (op_i)
      SGNJ: begin
        case (rnd_mode_i)
          RNE:     res_w = {sign[1], opnd[0][Width-2:0]};
          RTZ:     res_w = {~sign[1], opnd[0][Width-2:0]};
          RDN:     res_w = {sign[0] ^ sign[1], opnd[0][Width-2:0]};
          RUP:     res_w = opnd[0];
          default: res_w = '0;
        endcase
        comp_res.ext = op_mod_i ? res_w[Width-1] : 1'b1;
      end
      MINMAX: begin
        comp_res.status.nv = any_snan;
        comp_res.ext       = 1'b1;
        if (&is_nan) begin
          res_w = QNan;
        end else if (is_nan[0]) begin
          res_w = opnd[1];
        end else if (is_nan[1]) begin
          res_w = opnd[0];
        end else if (rnd_mode_i == RTZ) begin
          res_w = a_below_b ? opnd[1] : opnd[0];
        end else begin
          res_w = a_below_b ? opnd[0] : opnd[1];
        end
      end
      CMP: begin
        case (rnd_mode_i)
          RNE: begin
            comp_res.status.nv = any_nan;
            cmp_raw            = ~any_nan & (cmp_lt | cmp_eq);
          end
          RTZ: begin
            comp_res.status.nv = any_nan;
            cmp_raw            = ~any_nan & cmp_lt;
          end
          RDN: begin
            comp_res.status.nv = any_snan;
            cmp_raw            = ~any_nan & cmp_eq;
          end
          default: cmp_raw = 1'b0;
        endcase
        res_w = Width'(cmp_raw ^ op_mod_i);
      end
      CLASSIFY: begin
        comp_res.is_class = 1'b1;
      end
      default: ;
    endcase
    comp_res.result = FLEN'(res_w);
  end

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  payload_t               stage_data [NumPipeRegs+1];
  logic [NumPipeRegs:0]   stage_valid;
  logic [NumPipeRegs:0]   stage_ready;

  assign stage_data[0].res      = comp_res;
  assign stage_data[0].tag      = tag_i;
  assign stage_data[0].aux      = aux_i;
  assign stage_valid[0]         = in_valid_i;
  assign stage_ready[NumPipeRegs] = out_ready_i;
  assign in_ready_o             = stage_ready[0];

  for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
    fpnew_noncomp_stage #(
      .PayloadT (payload_t)
    ) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (stage_valid[k]),
      .in_ready_o  (stage_ready[k]),
      .in_data_i   (stage_data[k]),
      .out_valid_o (stage_valid[k+1]),
      .out_ready_i (stage_ready[k+1]),
      .out_data_o  (stage_data[k+1])
    );
  end

  if (NumPipeRegs > 0) begin : g_busy
    assign busy_o = |stage_valid[NumPipeRegs:1];
  end else begin : g_no_busy
    assign busy_o = 1'b0;
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, flush_i};
  end

  if (Width < FLEN) begin : g_narrow
    logic unused_upper;
    assign unused_upper = ^stage_data[NumPipeRegs].res.result[FLEN-1:Width];
  end

  assign out_valid_o     = stage_valid[NumPipeRegs];
  assign result_o        = stage_data[NumPipeRegs].res.result[Width-1:0];
  assign status_o        = stage_data[NumPipeRegs].res.status;
  assign extension_bit_o = stage_data[NumPipeRegs].res.ext;
  assign class_mask_o    = stage_data[NumPipeRegs].res.class_mask;
  assign is_class_o      = stage_data[NumPipeRegs].res.is_class;
  assign tag_o           = stage_data[NumPipeRegs].tag;
  assign aux_o           = stage_data[NumPipeRegs].aux;

endmodule

// File: tb/tb_fpnew_noncomp_pipe.sv
module tb_fpnew_noncomp_pipe;
  import fpnew_pkg::*;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;

  typedef struct {
    logic [31:0] res;
    logic        nv;
    logic        ext;
    logic [9:0]  cls;
    logic        is_class;
    logic [7:0]  tag;
    logic [3:0]  aux;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0][31:0] operands;
  logic [1:0]      is_boxed;
  roundmode_e      rnd;
  operation_e      op;
  logic            op_mod;
  logic [7:0]      tag;
  logic [3:0]      aux;
  logic            in_valid, out_ready, flush;

  logic [31:0] res_o   [4];
  logic [4:0]  st_o    [4];
  logic        ext_o   [4];
  logic [9:0]  cls_o   [4];
  logic        iscls_o [4];
  logic [7:0]  tag_o   [4];
  logic [3:0]  aux_o   [4];
  logic        ovalid  [4];
  logic        iready  [4];
  logic        busy    [4];

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Instance g has NumPipeRegs = g; all share the request-side inputs.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    fpnew_noncomp_pipe #(
      .FpFormat    (FP32),
      .NumPipeRegs (g),
      .TagType     (logic [7:0]),
      .AuxType     (logic [3:0])
    ) u_dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .operands_i      (operands),
      .is_boxed_i      (is_boxed),
      .rnd_mode_i      (rnd),
      .op_i            (op),
      .op_mod_i        (op_mod),
      .tag_i           (tag),
      .aux_i           (aux),
      .in_valid_i      (in_valid),
      .in_ready_o      (iready[g]),
      .flush_i         (flush),
      .result_o        (res_o[g]),
      .status_o        (st_o[g]),
      .extension_bit_o (ext_o[g]),
      .class_mask_o    (cls_o[g]),
      .is_class_o      (iscls_o[g]),
      .tag_o           (tag_o[g]),
      .aux_o           (aux_o[g]),
      .out_valid_o     (ovalid[g]),
      .out_ready_i     (out_ready),
      .busy_o          (busy[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model (value-level, real arithmetic for ordering)
  // ---------------------------------------------------------------------------
  function automatic logic is_nan32(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic logic is_snan32(logic [31:0] x);
    return is_nan32(x) && !x[22];
  endfunction

  function automatic real fp_val(logic [31:0] x);
    real m;
    int  e;
    e = int'(x[30:23]);
    if (e == 255) m = 1.0e300;
    else if (e == 0) m = real'(x[22:0]) * (2.0 ** (-149));
    else m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [9:0] classify32(logic [31:0] x);
    int bitpos;
    if (is_nan32(x)) bitpos = is_snan32(x) ? 8 : 9;
    else if (x[30:23] == 8'hFF) bitpos = x[31] ? 0 : 7;
    else if (x[30:0] == 0) bitpos = x[31] ? 3 : 4;
    else if (x[30:23] == 0) bitpos = x[31] ? 2 : 5;
    else bitpos = x[31] ? 1 : 6;
    return 10'(1) << bitpos;
  endfunction

  function automatic exp_t model(logic [31:0] a_raw, logic [31:0] b_raw, logic [1:0] boxed,
                                 roundmode_e rm, operation_e opc, logic mod);
    exp_t        e;
    logic [31:0] a, b, lo, hi;
    real         va, vb;
    logic        r;
    a = boxed[0] ? a_raw : QNAN32;
    b = boxed[1] ? b_raw : QNAN32;
    va = fp_val(a);
    vb = fp_val(b);
    e = '{res: 32'h0, nv: 1'b0, ext: 1'b0, cls: 10'h0, is_class: 1'b0, tag: 8'h0, aux: 4'h0};
    r = 1'b0;
    if (opc == SGNJ) begin
      if (rm == RNE) e.res = {b[31], a[30:0]};
      else if (rm == RTZ) e.res = {!b[31], a[30:0]};
      else if (rm == RDN) e.res = {a[31] ^ b[31], a[30:0]};
      else e.res = a;
      e.ext = mod ? e.res[31] : 1'b1;
    end else if (opc == MINMAX) begin
      e.ext = 1'b1;
      e.nv  = is_snan32(a) || is_snan32(b);
      if (is_nan32(a) && is_nan32(b)) e.res = QNAN32;
      else if (is_nan32(a)) e.res = b;
      else if (is_nan32(b)) e.res = a;
      else begin
        if (va < vb) begin lo = a; hi = b; end
        else if (vb < va) begin lo = b; hi = a; end
        else if (a[31] && !b[31]) begin lo = a; hi = b; end
        else begin lo = b; hi = a; end
        e.res = (rm == RNE) ? lo : hi;
      end
    end else if (opc == CMP) begin
      if (rm == RDN) begin
        e.nv = is_snan32(a) || is_snan32(b);
        r = !is_nan32(a) && !is_nan32(b) && (va == vb);
      end else begin
        e.nv = is_nan32(a) || is_nan32(b);
        if (!e.nv) r = (rm == RNE) ? (va <= vb) : (va < vb);
      end
      e.res = {31'b0, r ^ mod};
    end else begin
      e.cls      = classify32(a);
      e.is_class = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [10];
    int          k;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                 32'h7F80_0001, 32'hFF80_0001, 32'h0000_0001, 32'h3F80_0000, 32'hBF80_0000};
    k = $urandom_range(0, 19);
    if (k < 10) return specials[k];
    return $urandom;
  endfunction

  task automatic randomize_inputs();
    int k;
    operands[0] = rand_operand();
    operands[1] = ($urandom_range(0, 7) == 0) ? operands[0] : rand_operand();
    is_boxed    = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
    op_mod      = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 3);
    case (k)
      0:       begin op = SGNJ;   rnd = roundmode_e'(3'($urandom_range(0, 3))); end
      1:       begin op = MINMAX; rnd = roundmode_e'(3'($urandom_range(0, 1))); end
      2:       begin op = CMP;    rnd = roundmode_e'(3'($urandom_range(0, 2))); end
      default: begin op = CLASSIFY; rnd = RNE; end
    endcase
    tag = 8'($urandom);
    aux = 4'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    #1;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (ovalid[i] !== 1'b0) $display("FAIL reset_out_valid n=%0d got %b want 0", i, ovalid[i]);
      else n_pass++;
      n_checks++;
      if (busy[i] !== 1'b0) $display("FAIL reset_busy n=%0d got %b want 0", i, busy[i]);
      else n_pass++;
      n_checks++;
      if (iready[i] !== 1'b1) $display("FAIL reset_in_ready n=%0d got %b want 1", i, iready[i]);
      else n_pass++;
    end
  endtask

  task automatic test_directed();
    logic [31:0] da   [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0001,
                              32'h7FC0_0000, 32'h8000_0000, 32'h3F80_0000, 32'hFF80_0000};
    logic [31:0] db   [8] = '{32'h8000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000,
                              32'h7FC0_0000, 32'h0000_0000, 32'hBF80_0000, 32'h0000_0000};
    logic [1:0]  dbox [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
    roundmode_e  drm  [8] = '{RNE, RTZ, RNE, RNE, RDN, RDN, RNE, RNE};
    operation_e  dop  [8] = '{MINMAX, MINMAX, MINMAX, CMP, CMP, CMP, SGNJ, CLASSIFY};
    logic        dmod [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [31:0] eres [8] = '{32'h8000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h0,
                              32'h0, 32'h0, 32'hFFC0_0000, 32'h0};
    logic        env  [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    logic        eext [8] = '{1, 1, 1, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      operands[0] = da[i]; operands[1] = db[i]; is_boxed = dbox[i];
      rnd = drm[i]; op = dop[i]; op_mod = dmod[i]; tag = 8'(i);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if (ovalid[1] !== 1'b1) $display("FAIL dir%0d_valid got %b want 1", i, ovalid[1]);
      else n_pass++;
      if (dop[i] != CLASSIFY) begin
        n_checks++;
        if (res_o[1] !== eres[i]) $display("FAIL dir%0d_result got %h want %h", i, res_o[1], eres[i]);
        else n_pass++;
      end else begin
        n_checks++;
        if (cls_o[1] !== 10'h001) $display("FAIL dir%0d_class got %h want 001", i, cls_o[1]);
        else n_pass++;
      end
      n_checks++;
      if (st_o[1] !== {env[i], 4'b0}) $display("FAIL dir%0d_status got %b want %b", i, st_o[1],
                                                {env[i], 4'b0});
      else n_pass++;
      n_checks++;
      if (ext_o[1] !== eext[i]) $display("FAIL dir%0d_ext got %b want %b", i, ext_o[1], eext[i]);
      else n_pass++;
      n_checks++;
      if (iscls_o[1] !== (dop[i] == CLASSIFY)) $display("FAIL dir%0d_is_class got %b", i, iscls_o[1]);
      else n_pass++;
    end
  endtask

  task automatic test_comb_n0();
    do_reset();
    @(negedge clk);
    operands[0] = 32'h3F80_0000; operands[1] = 32'h4000_0000; is_boxed = 2'b11;
    op = CMP; rnd = RNE; op_mod = 1'b0; tag = 8'h5A; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    n_checks++;
    if (res_o[0] !== 32'h1) $display("FAIL n0_result got %h want 00000001", res_o[0]);
    else n_pass++;
    n_checks++;
    if (ovalid[0] !== 1'b1) $display("FAIL n0_out_valid got %b want 1", ovalid[0]);
    else n_pass++;
    n_checks++;
    if (iready[0] !== 1'b0) $display("FAIL n0_in_ready_low got %b want 0", iready[0]);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (iready[0] !== 1'b1) $display("FAIL n0_in_ready_high got %b want 1", iready[0]);
    else n_pass++;
    n_checks++;
    if (busy[0] !== 1'b0) $display("FAIL n0_busy got %b want 0", busy[0]);
    else n_pass++;
    n_checks++;
    if (tag_o[0] !== 8'h5A) $display("FAIL n0_tag got %h want 5a", tag_o[0]);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randomize_inputs();
      tag = 8'(10 + i); in_valid = 1'b1;
      #1;
      n_checks++;
      if (iready[2] !== (i < 2)) $display("FAIL b2b_in_ready%0d got %b want %b", i, iready[2], i < 2);
      else n_pass++;
      @(posedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++;
      if (ovalid[2] !== (i < 2)) $display("FAIL b2b_out_valid%0d got %b want %b", i, ovalid[2], i < 2);
      else n_pass++;
      if (i < 2) begin
        n_checks++;
        if (tag_o[2] !== 8'(10 + i)) $display("FAIL b2b_tag%0d got %0d want %0d", i, tag_o[2], 10 + i);
        else n_pass++;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randomize_inputs();
      tag = 8'(i); in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (busy[3] !== 1'b1) $display("FAIL flush_busy_before got %b want 1", busy[3]);
    else n_pass++;
    flush = 1'b1; in_valid = 1'b1; tag = 8'd99;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (ovalid[3] !== 1'b0) $display("FAIL flush_out_valid got %b want 0", ovalid[3]);
    else n_pass++;
    n_checks++;
    if (busy[3] !== 1'b0) $display("FAIL flush_busy got %b want 0", busy[3]);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (ovalid[3] !== 1'b0) $display("FAIL flush_stale%0d got %b want 0", i, ovalid[3]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      randomize_inputs();
      in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (ovalid[i] !== 1'b0) $display("FAIL midrst_out_valid n=%0d got %b want 0", i, ovalid[i]);
      else n_pass++;
      n_checks++;
      if (busy[i] !== 1'b0) $display("FAIL midrst_busy n=%0d got %b want 0", i, busy[i]);
      else n_pass++;
      n_checks++;
      if (iready[i] !== 1'b1) $display("FAIL midrst_in_ready n=%0d got %b want 1", i, iready[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    exp_t e, got;
    do_reset();
    sb.delete();
    for (int cyc = 0; cyc < 340; cyc++) begin
      @(negedge clk);
      randomize_inputs();
      if (cyc < 320) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (ovalid[2] && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL rnd_unexpected got tag %h want no output", tag_o[2]);
        end else begin
          e = sb.pop_front();
          got = '{res: res_o[2], nv: st_o[2][4], ext: ext_o[2], cls: cls_o[2],
                  is_class: iscls_o[2], tag: tag_o[2], aux: aux_o[2]};
          if (got.tag !== e.tag || got.aux !== e.aux || got.ext !== e.ext ||
              got.is_class !== e.is_class || st_o[2] !== {e.nv, 4'b0} ||
              (!e.is_class && got.res !== e.res) || (e.is_class && got.cls !== e.cls)) begin
            $display("FAIL rnd_result got res=%h st=%b ext=%b cls=%h ic=%b tag=%h aux=%h want res=%h nv=%b ext=%b cls=%h ic=%b tag=%h aux=%h",
                     got.res, st_o[2], got.ext, got.cls, got.is_class, got.tag, got.aux,
                     e.res, e.nv, e.ext, e.cls, e.is_class, e.tag, e.aux);
          end else begin
            n_pass++;
          end
        end
      end
      if (in_valid && iready[2]) begin
        e = model(operands[0], operands[1], is_boxed, rnd, op, op_mod);
        e.tag = tag;
        e.aux = aux;
        sb.push_back(e);
      end
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL rnd_drain got %0d pending want 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    operands = '0; is_boxed = 2'b11; rnd = RNE; op = SGNJ; op_mod = 1'b0;
    tag = '0; aux = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_directed();
    test_comb_n0();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
